// File: rtl/seq_div_sqrt_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_sqrt_if
// Purpose  : Request/result bundle between the controller (master) and the
//            sequential divide / square-root unit (slave).
// Signals  : start  - request, a low->high change is one request
//            mode   - 0 divide, 1 square root
//            a_in   - dividend / radicand (N_W bits, unsigned)
//            b_in   - divisor (D_W bits, unsigned)
//            result - result (N_W+F_W bits), stable while done is high
//            done   - result valid (level)
//            busy   - computation in progress
//            divz   - last divide had a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
interface seq_div_sqrt_if #(
    parameter int N_W = 16,
    parameter int D_W = 8,
    parameter int F_W = 8
);
    logic                 start;
    logic                 mode;
    logic [N_W-1:0]       a_in;
    logic [D_W-1:0]       b_in;
    logic [N_W+F_W-1:0]   result;
    logic                 done;
    logic                 busy;
    logic                 divz;

    modport master (
        output start, mode, a_in, b_in,
        input  result, done, busy, divz
    );

    modport slave (
        input  start, mode, a_in, b_in,
        output result, done, busy, divz
    );
endinterface
`default_nettype wire

// File: rtl/seq_div_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_sqrt
// Purpose  : Multi-cycle unsigned fixed-point divider and integer square root.
//            One result bit per clock (restoring algorithm), half-LSB upward
//            rounding, divide-by-zero saturates to all ones.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - seq_div_sqrt_if.slave (start/mode/a_in/b_in in,
//                     result/done/busy/divz out)
// Config   : DIVSQRT_SQRT_EN - when defined the square-root path exists and
//            mode selects it; otherwise mode is ignored and every request is
//            a divide.
// Latency  : divide N_W+F_W+2 edges after accept, zero divisor 1 edge,
//            square root N_W/2+1 edges.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_sqrt #(
    parameter int N_W = 16,   // dividend / radicand width, must be even
    parameter int D_W = 8,    // divisor width
    parameter int F_W = 8     // fractional bits of the divide result
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    seq_div_sqrt_if.slave bus
);

    localparam int Q_W     = N_W + F_W;
    localparam int c_CNT_W = $clog2(Q_W + 2);
    // Divide runs Q_W+1 steps: counter values 0..Q_W.
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(Q_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_last_step;
    logic                 w_div_by_zero;
    logic                 w_is_sqrt;
    logic                 w_mode_in;

    logic                 r_start_q;
    logic [D_W-1:0]       r_b;
    // Divide: holds the shifted numerator; quotient bits enter at the LSB as
    // numerator bits leave at the MSB, so after Q_W+1 steps it holds q.
    // Sqrt: the low N_W bits hold the radicand, consumed two bits per step.
    logic [Q_W:0]         r_acc;
    logic [D_W:0]         r_rem;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [Q_W-1:0]       r_result;
    logic                 r_divz;

    logic [Q_W:0]         w_acc_load;
    logic [Q_W:0]         w_acc_step;
    logic [Q_W-1:0]       w_round_result;

    // ------------------------------------------------------------------
    // Divide step: shift next numerator bit into the partial remainder,
    // subtract the divisor when it fits.
    // ------------------------------------------------------------------
    logic [D_W:0]         w_div_shift;
    logic                 w_div_ge;
    logic [D_W:0]         w_div_rem_nxt;
    logic [Q_W-1:0]       w_div_round;

    // The remainder is always below the divisor, so its top bit is zero
    // before the shift and nothing is lost by the truncation.
    assign w_div_shift   = (D_W+1)'({r_rem, r_acc[Q_W]});
    assign w_div_ge      = (w_div_shift >= {1'b0, r_b});
    assign w_div_rem_nxt = w_div_ge ? (w_div_shift - {1'b0, r_b}) : w_div_shift;
    // q carries one extra fraction bit; (q+1)>>1 == (q>>1) + q[0].
    assign w_div_round   = r_acc[Q_W:1] + Q_W'(r_acc[0]);

`ifdef DIVSQRT_SQRT_EN
    // ------------------------------------------------------------------
    // Square root, digit by digit: bring down two radicand bits, try
    // subtracting 4*root+1.
    // ------------------------------------------------------------------
    localparam int c_R_W  = N_W / 2;
    localparam int c_SR_W = N_W / 2 + 2;
    localparam logic [c_CNT_W-1:0] c_SQ_LAST = c_CNT_W'(c_R_W - 1);

    logic                 r_mode;
    logic [c_SR_W-1:0]    r_srem;
    logic [c_R_W-1:0]     r_root;
    logic [c_SR_W-1:0]    w_sq_shift;
    logic [c_SR_W-1:0]    w_sq_trial;
    logic                 w_sq_ge;
    logic                 w_sq_up;
    logic [c_R_W-1:0]     w_sq_rounded;

    // The remainder after k steps is at most 2*root, so 4*rem+3 always fits
    // in c_SR_W bits and the truncation drops only zeros.
    assign w_sq_shift   = c_SR_W'({r_srem, r_acc[N_W-1:N_W-2]});
    assign w_sq_trial   = {r_root, 2'b01};
    assign w_sq_ge      = (w_sq_shift >= w_sq_trial);
    // sqrt(A) >= r + 1/2  <=>  A >= r*r + r + 1  <=>  rem > r
    assign w_sq_up      = (r_srem > {2'b00, r_root});
    assign w_sq_rounded = (w_sq_up && !(&r_root)) ? (r_root + c_R_W'(1)) : r_root;

    assign w_mode_in      = bus.mode;
    assign w_is_sqrt      = r_mode;
    assign w_last_step    = r_mode ? (r_cnt == c_SQ_LAST) : (r_cnt == c_DIV_LAST);
    assign w_round_result = r_mode ? Q_W'(w_sq_rounded) : w_div_round;
    assign w_acc_step     = r_mode ? {r_acc[Q_W:N_W], r_acc[N_W-3:0], 2'b00}
                                   : {r_acc[Q_W-1:0], w_div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
            r_srem <= '0;
            r_root <= '0;
        end else if (w_accept) begin
            r_mode <= bus.mode;
            r_srem <= '0;
            r_root <= '0;
        end else if (r_state == ST_ITER && r_mode) begin
            if (w_sq_ge) begin
                r_srem <= w_sq_shift - w_sq_trial;
                r_root <= {r_root[c_R_W-2:0], 1'b1};
            end else begin
                r_srem <= w_sq_shift;
                r_root <= {r_root[c_R_W-2:0], 1'b0};
            end
        end
    end
`else
    assign w_mode_in      = 1'b0;
    assign w_is_sqrt      = 1'b0;
    assign w_last_step    = (r_cnt == c_DIV_LAST);
    assign w_round_result = w_div_round;
    assign w_acc_step     = {r_acc[Q_W-1:0], w_div_ge};
`endif

    // Divide: numerator A * 2^(F_W+1). Sqrt: radicand in the low bits.
    assign w_acc_load    = w_mode_in ? (Q_W+1)'(bus.a_in) : {bus.a_in, (F_W+1)'(0)};
    assign w_div_by_zero = !w_is_sqrt && (r_b == '0);
    assign w_accept      = bus.start && !r_start_q && !w_busy;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !r_start_q) w_state_nxt = ST_ITER;
            end
            ST_ITER: begin
                w_busy = 1'b1;
                if (w_div_by_zero)    w_state_nxt = ST_FIN;
                else if (w_last_step) w_state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                w_done = 1'b1;
                if (bus.start && !r_start_q) w_state_nxt = ST_ITER;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_divz    <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (w_accept) begin
                        r_b    <= bus.b_in;
                        r_acc  <= w_acc_load;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_divz <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (w_div_by_zero) begin
                        r_result <= '1;
                        r_divz   <= 1'b1;
                    end else begin
                        r_acc <= w_acc_step;
                        if (!w_is_sqrt) r_rem <= w_div_rem_nxt;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_ROUND: begin
                    r_result <= w_round_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = w_done;
    assign bus.busy   = w_busy;
    assign bus.divz   = r_divz;

endmodule
`default_nettype wire
